// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings for the round-robin MUX front end.
package mux_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_A = 2'd1,
      ST_GNT_B = 2'd2
   } state_e;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_out_reg.sv
// Output holding register for the arbitrated channel: one beat of data plus its valid flag.
// space tells the arbiter whether a new beat may be accepted this cycle.
module mux_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             x_ready,
   output logic [WIDTH-1:0] x,
   output logic             x_valid,
   output logic             space
);

   logic [WIDTH-1:0] x_q, x_d;
   logic             x_valid_q, x_valid_d;

   // Load a new beat, drop a consumed one, otherwise hold.
   always_comb begin
      x_d       = x_q;
      x_valid_d = x_valid_q;
      if (load) begin
         x_d       = load_data;
         x_valid_d = 1'b1;
      end else if (x_ready) begin
         x_valid_d = 1'b0;
      end
   end

   // Register update; reset discards any beat in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         x_q       <= '0;
         x_valid_q <= 1'b0;
      end else begin
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign space   = !x_valid_q || x_ready;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded bursts in front of the 2:1 MUX.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no grant; S holds the previous select; no transfers
//  ST_GNT_A | channel A granted; A_READY follows output space
//  ST_GNT_B | channel B granted; B_READY follows output space
//
// The burst limit is tracked as a down-counter of beats left before the
// granted side must yield to a waiting peer; it saturates at zero.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BURST = 4,
   parameter int CNT_W = 3
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] A,
   input  logic             A_VALID,
   output logic             A_READY,
   input  logic [WIDTH-1:0] B,
   input  logic             B_VALID,
   output logic             B_READY,
   output logic             S,
   output logic [WIDTH-1:0] X,
   output logic             X_VALID,
   input  logic             X_READY
);

   localparam logic [CNT_W-1:0] LEFT_FULL = CNT_W'(BURST);
   localparam logic [CNT_W-1:0] LEFT_ONE  = CNT_W'(1);

   state_e           state_q, state_d;
   logic             s_q, s_d;
   logic             last_q, last_d;    // 1: B was granted last
   logic [CNT_W-1:0] left_q, left_d;

   logic             space;
   logic             own_is_b;
   logic             own_valid;
   logic             oth_valid;
   logic             xfer;
   logic             burst_done;
   logic [WIDTH-1:0] win_data;

   assign own_is_b   = (state_q == ST_GNT_B);
   assign own_valid  = own_is_b ? B_VALID : A_VALID;
   assign oth_valid  = own_is_b ? A_VALID : B_VALID;
   assign A_READY    = (state_q == ST_GNT_A) && space;
   assign B_READY    = (state_q == ST_GNT_B) && space;
   assign xfer       = (A_VALID && A_READY) || (B_VALID && B_READY);
   assign win_data   = own_is_b ? B : A;
   assign burst_done = (left_q == '0) || ((left_q == LEFT_ONE) && xfer);
   assign S          = s_q;

   mux_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .load      (xfer),
      .load_data (win_data),
      .x_ready   (X_READY),
      .x         (X),
      .x_valid   (X_VALID),
      .space     (space)
   );

   // Grant selection, burst accounting and round-robin history.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      last_d  = last_q;
      left_d  = left_q;
      unique case (state_q)
         ST_IDLE: begin
            if (A_VALID && (!B_VALID || last_q)) begin
               state_d = ST_GNT_A;
               s_d     = SEL_A;
            end else if (B_VALID) begin
               state_d = ST_GNT_B;
               s_d     = SEL_B;
            end
         end
         ST_GNT_A, ST_GNT_B: begin
            if (oth_valid && (burst_done || !own_valid)) begin
               state_d = own_is_b ? ST_GNT_A : ST_GNT_B;
               s_d     = own_is_b ? SEL_A : SEL_B;
               left_d  = LEFT_FULL;
               last_d  = own_is_b;
            end else if (!own_valid) begin
               state_d = ST_IDLE;
               left_d  = LEFT_FULL;
               last_d  = own_is_b;
            end else if (xfer && (left_q != '0)) begin
               left_d  = left_q - LEFT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            left_d  = LEFT_FULL;
         end
      endcase
   end

   // Arbiter state registers; reset leaves A first in line on a tie.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         s_q     <= SEL_A;
         last_q  <= 1'b1;
         left_q  <= LEFT_FULL;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         last_q  <= last_d;
         left_q  <= left_d;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vectors, corner sequences and randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_mux_rr_arbiter;

   localparam int BURST = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] a_data, b_data, x;
   logic       a_valid, b_valid, a_ready, b_ready, s, x_valid, x_ready;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model
   int         m_g;      // -1 idle, 0 = A granted, 1 = B granted
   int         m_cnt;
   int         m_last;   // side granted most recently
   bit         m_xv;
   logic [7:0] m_x;
   bit         m_s;
   bit         m_acc_a, m_acc_b;
   bit         smp_ar, smp_br;

   typedef struct {
      bit         av;
      logic [7:0] a;
      bit         bv;
      logic [7:0] b;
      bit         xr;
      bit         ar;
      bit         br;
      bit         xv;
      logic [7:0] xd;
      bit         s;
   } vec_t;

   vec_t tbl [8];

   mux_rr_arbiter #(.WIDTH(8), .BURST(BURST), .CNT_W(3)) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .A       (a_data),
      .A_VALID (a_valid),
      .A_READY (a_ready),
      .B       (b_data),
      .B_VALID (b_valid),
      .B_READY (b_ready),
      .S       (s),
      .X       (x),
      .X_VALID (x_valid),
      .X_READY (x_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_g = -1; m_cnt = 0; m_last = 1; m_xv = 0; m_x = '0; m_s = 0;
      m_acc_a = 0; m_acc_b = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      a_valid = 0; b_valid = 0; a_data = '0; b_data = '0; x_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs, check READY against the model, advance the model, check registered outputs.
   task automatic step(input bit av, input logic [7:0] a, input bit bv, input logic [7:0] b, input bit xr);
      bit         vld [2];
      logic [7:0] dat [2];
      bit         rdy [2];
      bit         xf;
      int         own, oth, nc;
      @(negedge clk);
      a_valid = av; a_data = a; b_valid = bv; b_data = b; x_ready = xr;
      #1;
      vld[0] = av; vld[1] = bv; dat[0] = a; dat[1] = b;
      for (int i = 0; i < 2; i++) rdy[i] = (m_g == i) && (!m_xv || xr);
      smp_ar = a_ready; smp_br = b_ready;
      check("a_ready", a_ready, rdy[0]);
      check("b_ready", b_ready, rdy[1]);
      xf = 0; m_acc_a = 0; m_acc_b = 0;
      if (m_g >= 0 && vld[m_g] && rdy[m_g]) begin
         xf = 1; m_x = dat[m_g]; m_xv = 1;
         if (m_g == 0) m_acc_a = 1; else m_acc_b = 1;
      end else if (xr) begin
         m_xv = 0;
      end
      if (m_g < 0) begin
         if (av && bv) m_g = 1 - m_last;
         else if (av)  m_g = 0;
         else if (bv)  m_g = 1;
         if (m_g >= 0) m_s = (m_g == 1);
      end else begin
         own = m_g; oth = 1 - m_g; nc = m_cnt + (xf ? 1 : 0);
         if (vld[oth] && (nc >= BURST || !vld[own])) begin
            m_last = own; m_g = oth; m_cnt = 0; m_s = (oth == 1);
         end else if (!vld[own]) begin
            m_last = own; m_g = -1; m_cnt = 0;
         end else begin
            m_cnt = (nc > BURST) ? BURST : nc;
         end
      end
      @(posedge clk);
      #1;
      check("s", s, m_s);
      check("x_valid", x_valid, m_xv);
      check("x", x, m_x);
   endtask

   initial begin
      int         ia, ib, k, grp, idx;
      logic [7:0] ex;

      rst_n = 1'b0;
      a_valid = 0; b_valid = 0; a_data = '0; b_data = '0; x_ready = 0;
      model_reset();

      //            av a      bv b      xr ar br xv x      s
      tbl[0] = '{1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
      tbl[1] = '{1, 8'h11, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0};
      tbl[2] = '{1, 8'h12, 0, 8'h00, 1, 1, 0, 1, 8'h12, 0};
      tbl[3] = '{1, 8'h13, 0, 8'h00, 1, 1, 0, 1, 8'h13, 0};
      tbl[4] = '{1, 8'h14, 0, 8'h00, 1, 1, 0, 1, 8'h14, 0};
      tbl[5] = '{1, 8'h15, 0, 8'h00, 1, 1, 0, 1, 8'h15, 0};
      tbl[6] = '{1, 8'h16, 0, 8'h00, 1, 1, 0, 1, 8'h16, 0};
      tbl[7] = '{0, 8'h16, 0, 8'h00, 1, 1, 0, 0, 8'h16, 0};

      do_reset();
      #1;
      check("rst_s", s, 0);
      check("rst_x_valid", x_valid, 0);
      check("rst_x", x, 0);

      // only A valid: six beats, one cycle latency, S stays on A
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].av, tbl[i].a, tbl[i].bv, tbl[i].b, tbl[i].xr);
         check("tbl_a_ready", smp_ar, tbl[i].ar);
         check("tbl_b_ready", smp_br, tbl[i].br);
         check("tbl_x_valid", x_valid, tbl[i].xv);
         check("tbl_x", x, tbl[i].xd);
         check("tbl_s", s, tbl[i].s);
      end

      // both valid: bursts of four, alternating
      do_reset();
      ia = 0; ib = 0;
      step(1, 8'hA0, 1, 8'hB0, 1);
      check("rr_first_grant_s", s, 0);
      for (int j = 1; j <= 16; j++) begin
         step(1, 8'(8'hA0 + ia), 1, 8'(8'hB0 + ib), 1);
         if (m_acc_a) ia++;
         if (m_acc_b) ib++;
         k   = j - 1;
         grp = k / 4;
         idx = (grp / 2) * 4 + (k % 4);
         ex  = (grp % 2 == 1) ? 8'(8'hB0 + idx) : 8'(8'hA0 + idx);
         check("rr_x", x, ex);
         check("rr_x_valid", x_valid, 1);
         check("rr_s", s, (j / 4) % 2);
      end

      // asynchronous reset mid-burst with a beat held in X
      step(1, 8'(8'hA0 + ia), 1, 8'(8'hB0 + ib), 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_s", s, 0);
      check("arst_x", x, 0);
      check("arst_x_valid", x_valid, 0);
      check("arst_a_ready", a_ready, 0);
      check("arst_b_ready", b_ready, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // backpressure while A granted
      do_reset();
      step(1, 8'hA0, 0, 8'h00, 1);
      step(1, 8'hA0, 0, 8'h00, 1);
      check("bp_first_x", x, 8'hA0);
      for (int j = 0; j < 3; j++) begin
         step(1, 8'hA1, 0, 8'h00, 0);
         check("bp_a_ready", smp_ar, 0);
         check("bp_x_hold", x, 8'hA0);
         check("bp_x_valid", x_valid, 1);
      end
      step(1, 8'hA1, 0, 8'h00, 1);
      check("bp_resume_ready", smp_ar, 1);
      check("bp_resume_x", x, 8'hA1);
      step(1, 8'hA2, 0, 8'h00, 1);
      check("bp_next_x", x, 8'hA2);

      // idle tie after a B grant goes to A, after an A grant goes to B
      do_reset();
      step(0, 8'h00, 1, 8'h55, 1);
      check("tie_b_grant_s", s, 1);
      step(0, 8'h00, 1, 8'h55, 1);
      step(0, 8'h00, 0, 8'h00, 1);
      check("tie_idle_hold_s", s, 1);
      step(1, 8'h61, 1, 8'h71, 1);
      check("tie_after_b_s", s, 0);
      step(1, 8'h61, 1, 8'h71, 1);
      check("tie_after_b_x", x, 8'h61);
      step(0, 8'h00, 0, 8'h00, 1);
      check("tie_idle2_s", s, 0);
      step(1, 8'h62, 1, 8'h72, 1);
      check("tie_after_a_s", s, 1);
      step(1, 8'h62, 1, 8'h72, 1);
      check("tie_after_a_x", x, 8'h72);

      // early release: B drops after two beats while A waits
      do_reset();
      step(0, 8'h00, 1, 8'hB0, 1);
      step(1, 8'hA0, 1, 8'hB0, 1);
      step(1, 8'hA0, 1, 8'hB1, 1);
      check("er_b_beat2", x, 8'hB1);
      check("er_s_b", s, 1);
      step(1, 8'hA0, 0, 8'h00, 1);
      check("er_switch_s", s, 0);
      step(1, 8'hA0, 0, 8'h00, 1);
      check("er_a_beat", x, 8'hA0);

      // randomized traffic against the model
      do_reset();
      for (int j = 0; j < 3000; j++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom),
              $urandom_range(0, 3) != 0, 8'($urandom),
              $urandom_range(0, 4) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
